// File: rtl/horner_eval_pkg.sv
// Shared types and constants for the Horner polynomial evaluator.
package horner_eval_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // Legal range of the coefficient count.
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 64;

  // Coefficient index width; a single-entry store still needs one address bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/horner_coef_rf.sv
// Coefficient register file: DEPTH x WIDTH, one write port, two
// combinational read ports, asynchronous clear. Writes to addresses
// at or beyond DEPTH match no entry and are dropped.
module horner_coef_rf
  import horner_eval_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [AW-1:0]    praddr_i,
  output logic [WIDTH-1:0] prdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Coefficient storage, cleared by reset, written one entry at a time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++)
        if (waddr_i == AW'(i)) mem_q[i] <= wdata_i;
    end
  end

  // Read muxes; out-of-range addresses return zero.
  always_comb begin
    rdata_o  = '0;
    prdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i  == AW'(i)) rdata_o  = mem_q[i];
      if (praddr_i == AW'(i)) prdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/horner_eval.sv
// Sequential Horner evaluator: result = sum c[i]*x^i mod 2^WIDTH,
// one multiply-accumulate per clock, DEPTH edges per evaluation.
// DEPTH legal range 1..64.
// Optional feature: define HORNER_EVAL_OVF_EN to add the sticky ovf output.
module horner_eval
  import horner_eval_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          x,
  input  logic                      coef_we,
  input  logic [addr_w(DEPTH)-1:0]  coef_addr,
  input  logic [WIDTH-1:0]          coef_data,
  output logic                      busy,
  output logic [WIDTH-1:0]          result,
  output logic                      done
`ifdef HORNER_EVAL_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int AW = addr_w(DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  // Pre-write copy of a coefficient overwritten in the start cycle, so the
  // evaluation sees the contents as they were when it was accepted.
  logic             pend_vld_q, pend_vld_d;
  logic [AW-1:0]    pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0] pend_old_q, pend_old_d;

  logic             idle, start_ok, we_ok;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata, prdata, coef_sel, acc_next;

  assign idle     = (state_q == IDLE);
  assign start_ok = start & idle;
  assign we_ok    = coef_we & idle;
  // In IDLE the top coefficient is presented for the start cycle.
  assign raddr    = idle ? AW'(DEPTH - 1) : idx_q;
  assign coef_sel = (pend_vld_q && pend_addr_q == idx_q) ? pend_old_q : rdata;

  horner_coef_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (we_ok),
    .waddr_i  (coef_addr),
    .wdata_i  (coef_data),
    .raddr_i  (raddr),
    .rdata_o  (rdata),
    .praddr_i (coef_addr),
    .prdata_o (prdata)
  );

`ifdef HORNER_EVAL_OVF_EN
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]     sum_full;
  logic               ovf_step;
  logic               ovf_q, ovf_d;

  assign prod_full = (2*WIDTH)'(acc_q) * (2*WIDTH)'(x_q);
  assign sum_full  = {1'b0, prod_full[WIDTH-1:0]} + {1'b0, coef_sel};
  assign acc_next  = sum_full[WIDTH-1:0];
  assign ovf_step  = (|prod_full[2*WIDTH-1:WIDTH]) | sum_full[WIDTH];
  assign ovf       = ovf_q;

  // Sticky overflow: cleared on start, accumulates over each ITER step.
  always_comb begin
    ovf_d = ovf_q;
    if (start_ok)           ovf_d = 1'b0;
    else if (state_q == ITER) ovf_d = ovf_q | ovf_step;
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
`else
  assign acc_next = acc_q * x_q + coef_sel;
`endif

  assign busy   = (state_q == ITER);
  assign result = result_q;
  assign done   = done_q;

  // Next-state logic: start capture, one MAC per ITER cycle, completion.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    result_d    = result_q;
    done_d      = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_old_d  = pend_old_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d = x;
          if (DEPTH == 1) begin
            result_d = rdata;
            done_d   = 1'b1;
          end else begin
            acc_d       = rdata;
            idx_d       = AW'(DEPTH - 2);
            state_d     = ITER;
            pend_vld_d  = coef_we;
            pend_addr_d = coef_addr;
            pend_old_d  = prdata;
          end
        end
      end
      ITER: begin
        acc_d = acc_next;
        idx_d = idx_q - AW'(1);
        if (idx_q == '0) begin
          result_d   = acc_next;
          done_d     = 1'b1;
          state_d    = IDLE;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_old_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      done_q      <= done_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_old_q  <= pend_old_d;
    end
  end

endmodule

// File: tb/tb_horner_eval.sv
// Directed bench for horner_eval: four instances covering (32,4), (32,3),
// (8,3) and (32,1). Define HORNER_EVAL_OVF_EN to also check ovf.
module tb_horner_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x, cd;
  logic [1:0]  ca;
  logic [3:0]  we, st;

  logic        a_busy, a_done, b_busy, b_done, c_busy, c_done, d_busy, d_done;
  logic [31:0] a_res, b_res, d_res;
  logic [7:0]  c_res;
`ifdef HORNER_EVAL_OVF_EN
  logic        a_ovf, b_ovf, c_ovf, d_ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  horner_eval #(.WIDTH(32), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .start(st[0]), .x(x), .coef_we(we[0]),
    .coef_addr(ca), .coef_data(cd), .busy(a_busy), .result(a_res), .done(a_done)
`ifdef HORNER_EVAL_OVF_EN
    , .ovf(a_ovf)
`endif
  );
  horner_eval #(.WIDTH(32), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .start(st[1]), .x(x), .coef_we(we[1]),
    .coef_addr(ca), .coef_data(cd), .busy(b_busy), .result(b_res), .done(b_done)
`ifdef HORNER_EVAL_OVF_EN
    , .ovf(b_ovf)
`endif
  );
  horner_eval #(.WIDTH(8), .DEPTH(3)) u_c (
    .clk(clk), .reset(reset), .start(st[2]), .x(x[7:0]), .coef_we(we[2]),
    .coef_addr(ca), .coef_data(cd[7:0]), .busy(c_busy), .result(c_res), .done(c_done)
`ifdef HORNER_EVAL_OVF_EN
    , .ovf(c_ovf)
`endif
  );
  horner_eval #(.WIDTH(32), .DEPTH(1)) u_d (
    .clk(clk), .reset(reset), .start(st[3]), .x(x), .coef_we(we[3]),
    .coef_addr(ca[0]), .coef_data(cd), .busy(d_busy), .result(d_res), .done(d_done)
`ifdef HORNER_EVAL_OVF_EN
    , .ovf(d_ovf)
`endif
  );

  // Stimulus helpers (no checking): one coefficient write, one start pulse.
  task automatic wr(input int s, input logic [1:0] a, input logic [31:0] d);
    we[s] = 1'b1; ca = a; cd = d;
    @(posedge clk); #1;
    we[s] = 1'b0;
  endtask

  task automatic go(input int s, input logic [31:0] xv);
    st[s] = 1'b1; x = xv;
    @(posedge clk); #1;
    st[s] = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_res !== 32'd0) begin
      failures++; $display("FAIL reset_a busy=%b done=%b result=%0d need 0/0/0", a_busy, a_done, a_res); end
    checks++; if (d_busy !== 1'b0 || d_done !== 1'b0 || d_res !== 32'd0) begin
      failures++; $display("FAIL reset_d busy=%b done=%b result=%0d need 0/0/0", d_busy, d_done, d_res); end
`ifdef HORNER_EVAL_OVF_EN
    checks++; if (c_ovf !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b need 0", c_ovf); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // c=[1,2,3,4], x=2 -> 49 after 4 edges.
  task automatic test_basic;
    int n;
    wr(0, 2'd0, 32'd1); wr(0, 2'd1, 32'd2); wr(0, 2'd2, 32'd3); wr(0, 2'd3, 32'd4);
    go(0, 32'd2);
    n = 1;
    checks++; if (a_busy !== 1'b1) begin
      failures++; $display("FAIL basic_busy got=%b need 1", a_busy); end
    while (!a_done && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 4) begin
      failures++; $display("FAIL basic_latency got=%0d need 4", n); end
    checks++; if (a_res !== 32'd49 || a_busy !== 1'b0) begin
      failures++; $display("FAIL basic_result got=%0d busy=%b need 49 busy=0", a_res, a_busy); end
`ifdef HORNER_EVAL_OVF_EN
    checks++; if (a_ovf !== 1'b0) begin
      failures++; $display("FAIL basic_ovf got=%b need 0", a_ovf); end
`endif
    @(posedge clk); #1;
    checks++; if (a_done !== 1'b0 || a_res !== 32'd49) begin
      failures++; $display("FAIL basic_hold done=%b result=%0d need 0/49", a_done, a_res); end
  endtask

  // c=[25,10,1], x=3 -> 64.
  task automatic test_square;
    int n;
    wr(1, 2'd0, 32'd25); wr(1, 2'd1, 32'd10); wr(1, 2'd2, 32'd1);
    go(1, 32'd3);
    n = 1;
    while (!b_done && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3 || b_res !== 32'd64) begin
      failures++; $display("FAIL square got lat=%0d result=%0d need lat=3 result=64", n, b_res); end
  endtask

  // WIDTH=8, c=[0,0,1], x=200 -> 40000 mod 256 = 64.
  task automatic test_wrap;
    int n;
    wr(2, 2'd2, 32'd1);
    go(2, 32'd200);
    n = 1;
    while (!c_done && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3 || c_res !== 8'd64) begin
      failures++; $display("FAIL wrap got lat=%0d result=%0d need lat=3 result=64", n, c_res); end
`ifdef HORNER_EVAL_OVF_EN
    checks++; if (c_ovf !== 1'b1) begin
      failures++; $display("FAIL wrap_ovf got=%b need 1", c_ovf); end
`endif
  endtask

  // DEPTH=1: start yields c[0] on the acceptance edge, busy never rises.
  task automatic test_depth1;
    wr(3, 2'd0, 32'd7);
    go(3, 32'd5);
    checks++; if (d_done !== 1'b1 || d_res !== 32'd7 || d_busy !== 1'b0) begin
      failures++; $display("FAIL depth1 done=%b result=%0d busy=%b need 1/7/0", d_done, d_res, d_busy); end
    @(posedge clk); #1;
    checks++; if (d_done !== 1'b0) begin
      failures++; $display("FAIL depth1_pulse done=%b need 0", d_done); end
  endtask

  // Writes at addresses >= DEPTH are dropped.
  task automatic test_oob;
    int n;
    wr(1, 2'd3, 32'd77);
    go(1, 32'd3);
    n = 1;
    while (!b_done && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (b_res !== 32'd64) begin
      failures++; $display("FAIL oob_b got=%0d need 64", b_res); end
    wr(3, 2'd1, 32'd9);
    go(3, 32'd0);
    checks++; if (d_res !== 32'd7) begin
      failures++; $display("FAIL oob_d got=%0d need 7", d_res); end
  endtask

  // Restart and coefficient write while busy are both ignored.
  task automatic test_ignore;
    int ndone, at;
    ndone = 0; at = 0;
    st[0] = 1'b1; x = 32'd3;
    @(posedge clk); #1;               // acceptance edge (cycle 1)
    we[0] = 1'b1; ca = 2'd0; cd = 32'd99; x = 32'd5;
    @(posedge clk); #1;               // cycle 2: start and write while busy
    st[0] = 1'b0; we[0] = 1'b0;
    if (a_done) begin ndone++; at = 2; end
    for (int c = 3; c <= 12; c++) begin
      @(posedge clk); #1;
      if (a_done) begin ndone++; at = c; end
    end
    // ((4*3+3)*3+2)*3+1 = 142
    checks++; if (ndone !== 1 || at !== 4 || a_res !== 32'd142) begin
      failures++; $display("FAIL busy_ignore dones=%0d at=%0d result=%0d need 1/4/142", ndone, at, a_res); end
    go(0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (a_res !== 32'd1) begin
      failures++; $display("FAIL busy_write_c0 got=%0d need 1", a_res); end
  endtask

  // Write in the start cycle completes but the evaluation sees old contents.
  task automatic test_same_cycle;
    logic [31:0] exp_q [4];
    exp_q[0] = 32'd10; exp_q[1] = 32'd16; exp_q[2] = 32'd16; exp_q[3] = 32'd20;
    for (int k = 0; k < 4; k++) begin
      st[0] = 1'b1; x = 32'd1;
      if (k == 0) begin we[0] = 1'b1; ca = 2'd3; cd = 32'd10; end
      if (k == 2) begin we[0] = 1'b1; ca = 2'd0; cd = 32'd5;  end
      @(posedge clk); #1;
      st[0] = 1'b0; we[0] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (a_done !== 1'b1 || a_res !== exp_q[k]) begin
        failures++; $display("FAIL same_cycle_%0d done=%b result=%0d need 1/%0d", k, a_done, a_res, exp_q[k]); end
      @(posedge clk); #1;
    end
  endtask

  // Reset two edges into an evaluation aborts it and clears coefficients.
  task automatic test_reset_abort;
    int ndone, n;
    ndone = 0;
    go(0, 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (a_res !== 32'd0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL abort_now result=%0d busy=%b done=%b need 0/0/0", a_res, a_busy, a_done); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (a_done) ndone++;
    end
    checks++; if (ndone !== 0 || a_res !== 32'd0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL abort_quiet dones=%0d result=%0d busy=%b need 0/0/0", ndone, a_res, a_busy); end
    go(0, 32'd2);
    n = 1;
    while (!a_done && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 4 || a_res !== 32'd0) begin
      failures++; $display("FAIL abort_fresh lat=%0d result=%0d need 4/0", n, a_res); end
  endtask

  initial begin
    reset = 1'b1; x = '0; cd = '0; ca = '0; we = '0; st = '0;
    test_reset;
    test_basic;
    test_square;
    test_wrap;
    test_depth1;
    test_oob;
    test_ignore;
    test_same_cycle;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/horner_eval.md
HORNER_EVAL -- requirements
Module: horner_eval

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, coefficient and result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of polynomial coefficients c[0..DEPTH-1]; legal range 1..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request an evaluation; sampled only in IDLE.
REQ-006 SHALL have port x, input, WIDTH bits: evaluation point, captured when start is accepted.
REQ-007 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-008 SHALL have port coef_addr, input, max(1,$clog2(DEPTH)) bits: coefficient index.
REQ-009 SHALL have port coef_data, input, WIDTH bits: coefficient write data.
REQ-010 SHALL have port busy, output, 1 bit: high while an evaluation is in progress.
REQ-011 SHALL have port result, output, WIDTH bits: last completed value of sum c[i]*x^i.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking result update.

Function
REQ-013 SHALL implement states IDLE and ITER only.
REQ-014 In IDLE with start=1 at edge k: capture x into x_q, acc <= c[DEPTH-1], idx <= DEPTH-2, busy <= 1, state <= ITER.
REQ-015 In ITER at each edge: acc <= acc*x_q + c[idx], idx <= idx-1.
REQ-016 When the ITER update uses idx=0: result <= new acc value, done <= 1, busy <= 0, state <= IDLE.
REQ-017 Latency SHALL be DEPTH edges from start acceptance to done assertion; next start accepted in the cycle after done.
REQ-018 DEPTH=1: start acceptance SHALL directly set result <= c[0], done <= 1, with busy remaining 0.
REQ-019 done SHALL be high for exactly one cycle per evaluation; result SHALL hold between completions.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH; every product and sum is truncated to WIDTH bits.
REQ-021 start while busy=1 SHALL be ignored (no queueing, no restart).
REQ-022 coef_we while busy=1 SHALL be ignored; coefficients are stable during evaluation.
REQ-023 coef_we and start in the same IDLE cycle: write SHALL complete and the evaluation SHALL use the pre-write contents.
REQ-024 coef_we with coef_addr >= DEPTH SHALL be ignored.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, busy=0, done=0, result=0, all c[i]=0, x_q=0, acc=0.
REQ-026 reset during ITER SHALL abort the evaluation with no done pulse and no result update.

Configuration
REQ-027 Macro HORNER_EVAL_OVF_EN SHALL add output ovf, 1 bit: sticky flag, set if any product or sum in the current evaluation exceeds WIDTH bits.
REQ-028 With HORNER_EVAL_OVF_EN: ovf is cleared on start acceptance, is valid when done=1, holds until the next start, and resets to 0.
REQ-029 Without HORNER_EVAL_OVF_EN: port ovf and its logic SHALL be absent, with function otherwise identical.

Structure
REQ-030 Package horner_eval_pkg SHALL hold the state enum typedef (IDLE, ITER) and the DEPTH legal-range constants.
REQ-031 The coefficient store SHALL be sub-module horner_coef_rf (DEPTH x WIDTH, one write port, combinational read by idx, async reset).

Verification
REQ-032 WIDTH=32, DEPTH=4, c=[1,2,3,4], x=2, start -> done pulse 4 cycles later, result=49, ovf=0.
REQ-033 DEPTH=3, c=[25,10,1], x=3 -> result=64 ((a+b)^2 with a=3, b=5).
REQ-034 WIDTH=8, DEPTH=3, c=[0,0,1], x=200 -> result=64 (40000 mod 256), ovf=1 when the macro is defined.
REQ-035 start pulsed again 1 cycle after acceptance, and coef_we to c[0]=99 while busy -> single done, result unchanged by either event.
REQ-036 reset asserted 2 cycles into a DEPTH=4 evaluation -> no done, result=0, busy=0; a fresh start after reset evaluates with all-zero coefficients -> result=0.
